// File: rtl/craft_pkg.sv
// craft_pkg: shared CRAFT-64 constants, permutations, round-constant table and FSM encoding.
package craft_pkg;
    localparam int CRAFT_ROUNDS = 32;
    localparam logic [3:0] RC_SEED_A = 4'h1;
    localparam logic [2:0] RC_SEED_B = 3'h1;
    localparam int NIBBLES = 16;
    localparam int NIB_W = 4;
    localparam logic [7:0] RC_TABLE [CRAFT_ROUNDS] = '{
        8'h11, 8'h84, 8'h42, 8'h25, 8'h96, 8'hc7, 8'h63, 8'hb1,
        8'h54, 8'ha2, 8'hd5, 8'he6, 8'hf7, 8'h73, 8'h31, 8'h14,
        8'h82, 8'h45, 8'h26, 8'h97, 8'hc3, 8'h61, 8'hb4, 8'h52,
        8'ha5, 8'hd6, 8'he7, 8'hf3, 8'h71, 8'h34, 8'h12, 8'h85
    };
    localparam logic [3:0] SBOX [NIBBLES] = '{
        4'hc, 4'ha, 4'hd, 4'h3, 4'he, 4'hb, 4'hf, 4'h7,
        4'h8, 4'h9, 4'h1, 4'h5, 4'h0, 4'h2, 4'h4, 4'h6
    };
    localparam int PERM_N [NIBBLES] = '{15, 12, 13, 14, 10, 9, 8, 11, 6, 5, 4, 7, 1, 2, 3, 0};
    localparam int PERM_Q [NIBBLES] = '{12, 10, 15, 5, 14, 8, 9, 2, 11, 3, 7, 4, 6, 0, 1, 13};
    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_FINAL, ST_DONE} state_e;
    // nibble 0 is the most significant nibble of a 64-bit word
    function automatic int nib_lo(input int i);
        return 60 - NIB_W * i;
    endfunction
endpackage

// File: rtl/craft_final_round.sv
// craft_final_round: truncated last round, ATK o ARC o MC without S-box or permutation.
module craft_final_round (
    input  logic [63:0] din,
    input  logic [63:0] tk,
    input  logic [7:0]  rc,
    output logic [63:0] dout
);
    assign dout = {din[63:48] ^ din[31:16] ^ din[15:0], din[47:32] ^ din[15:0], din[31:0]}
                ^ tk ^ {16'h0, rc, 40'h0};
endmodule

// File: rtl/craft_key_schedule.sv
// craft_key_schedule: selects tweakey TK[r mod 4] from K0||K1 and the tweak.
module craft_key_schedule
    import craft_pkg::*;
(
    input  logic [127:0] key,
    input  logic [63:0]  tweak,
    input  logic [7:0]   r,
    output logic [63:0]  tk
);
    logic [63:0] qt;
    logic unused_r;
    assign unused_r = ^r[7:2];
    always_comb begin
        qt = '0;
        for (int i = 0; i < NIBBLES; i++)
            qt[nib_lo(i) +: NIB_W] = tweak[nib_lo(PERM_Q[i]) +: NIB_W];
    end
    assign tk = (r[0] ? key[63:0] : key[127:64]) ^ (r[1] ? qt : tweak);
endmodule

// File: rtl/craft_round.sv
// craft_round: one full CRAFT round (MC, ARC, ATK, PN, SB), combinational.
module craft_round
    import craft_pkg::*;
(
    input  logic [63:0] din,
    input  logic [63:0] tk,
    input  logic [7:0]  rc,
    output logic [63:0] dout
);
    logic [63:0] lin;
    assign lin = {din[63:48] ^ din[31:16] ^ din[15:0], din[47:32] ^ din[15:0], din[31:0]}
               ^ tk ^ {16'h0, rc, 40'h0};
    // the S-box is nibble-wise, so substitution is folded into the PN scatter
    always_comb begin
        dout = '0;
        for (int i = 0; i < NIBBLES; i++)
            dout[nib_lo(PERM_N[i]) +: NIB_W] = SBOX[lin[nib_lo(i) +: NIB_W]];
    end
endmodule

// File: rtl/craft_encrypt_iter.sv
// craft_encrypt_iter: iterative CRAFT-64 encryption, one round per clock, start/done handshake.
module craft_encrypt_iter
    import craft_pkg::*;
#(
    parameter int NUM_ROUNDS = CRAFT_ROUNDS
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [63:0]  pt,
    input  logic [127:0] key,
    input  logic [63:0]  tweak,
    output logic         ready,
    output logic         busy,
    output logic         done,
    output logic [63:0]  ct
);
    state_e       st_q;
    logic [63:0]  state_q, tweak_q, ct_q;
    logic [127:0] key_q;
    logic [4:0]   round_q;
    logic [3:0]   a_q, a_d;
    logic [2:0]   b_q, b_d;
    logic         ready_q, done_q;
    logic [7:0]   rc;
    logic [63:0]  tk, rnd_out, fin_out;

    assign rc  = {a_q, 1'b0, b_q};
    assign a_d = {a_q[1] ^ a_q[0], a_q[3:1]};
    assign b_d = {b_q[1] ^ b_q[0], b_q[2:1]};

    craft_key_schedule u_ks (.key(key_q), .tweak(tweak_q), .r({3'b0, round_q}), .tk(tk));
    craft_round        u_rnd (.din(state_q), .tk(tk), .rc(rc), .dout(rnd_out));
    craft_final_round  u_fin (.din(state_q), .tk(tk), .rc(rc), .dout(fin_out));

    always_ff @(posedge clk) begin
        if (rst) begin
            st_q    <= ST_IDLE;
            ready_q <= 1'b1;
            done_q  <= 1'b0;
            ct_q    <= '0;
            round_q <= '0;
            a_q     <= RC_SEED_A;
            b_q     <= RC_SEED_B;
            state_q <= '0;
            key_q   <= '0;
            tweak_q <= '0;
        end else begin
            done_q <= 1'b0;
            case (st_q)
                ST_IDLE: if (start) begin
                    state_q <= pt;
                    key_q   <= key;
                    tweak_q <= tweak;
                    round_q <= '0;
                    a_q     <= RC_SEED_A;
                    b_q     <= RC_SEED_B;
                    ready_q <= 1'b0;
                    st_q    <= ST_RUN;
                end
                ST_RUN: begin
                    state_q <= rnd_out;
                    round_q <= round_q + 5'd1;
                    a_q     <= a_d;
                    b_q     <= b_d;
                    if (round_q == 5'(NUM_ROUNDS - 2))
                        st_q <= ST_FINAL;
                end
                ST_FINAL: begin
                    state_q <= fin_out;
                    ct_q    <= fin_out;
                    done_q  <= 1'b1;
                    st_q    <= ST_DONE;
                end
                ST_DONE: begin
                    ready_q <= 1'b1;
                    st_q    <= ST_IDLE;
                end
            endcase
        end
    end

    assign ready = ready_q;
    assign busy  = ~ready_q;
    assign done  = done_q;
    assign ct    = ct_q;
endmodule

// File: tb/tb_craft_encrypt_iter.sv
// tb_craft_encrypt_iter: randomized and directed checks of the CRAFT engine against a nibble-level model.
module tb_craft_encrypt_iter;
    localparam int SB [16] = '{12, 10, 13, 3, 14, 11, 15, 7, 8, 9, 1, 5, 0, 2, 4, 6};
    localparam int PN [16] = '{15, 12, 13, 14, 10, 9, 8, 11, 6, 5, 4, 7, 1, 2, 3, 0};
    localparam int QT [16] = '{12, 10, 15, 5, 14, 8, 9, 2, 11, 3, 7, 4, 6, 0, 1, 13};
    localparam logic [7:0] RCV [32] = '{
        8'h11, 8'h84, 8'h42, 8'h25, 8'h96, 8'hc7, 8'h63, 8'hb1,
        8'h54, 8'ha2, 8'hd5, 8'he6, 8'hf7, 8'h73, 8'h31, 8'h14,
        8'h82, 8'h45, 8'h26, 8'h97, 8'hc3, 8'h61, 8'hb4, 8'h52,
        8'ha5, 8'hd6, 8'he7, 8'hf3, 8'h71, 8'h34, 8'h12, 8'h85
    };
    localparam logic [127:0] J1_KEY = 128'h27a6781a43f364bc916708d5fbb5aefe;
    localparam logic [63:0]  J1_TWK = 64'h54cd94ffd0670a58;
    localparam logic [63:0]  J1_PT  = 64'h5734f006d8d88a3e;

    logic clk = 1'b0, rst, start, ready, busy, done;
    logic [63:0] pt, tweak, ct;
    logic [127:0] key;
    int n_cmp = 0, n_bad = 0;
    logic [63:0] tk0_seen;
    logic [7:0] rc_seen [2];

    craft_encrypt_iter dut (
        .clk(clk), .rst(rst), .start(start), .pt(pt), .key(key), .tweak(tweak),
        .ready(ready), .busy(busy), .done(done), .ct(ct)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] tk_ref(input logic [127:0] k, input logic [63:0] t, input int r);
        logic [63:0] tw;
        logic [63:0] kk;
        tw = t;
        if (r % 4 >= 2)
            for (int i = 0; i < 16; i++) tw[60 - 4 * i +: 4] = t[60 - 4 * QT[i] +: 4];
        kk = (r % 2 == 1) ? k[63:0] : k[127:64];
        return kk ^ tw;
    endfunction

    function automatic logic [63:0] ref_ct(input logic [63:0] p, input logic [127:0] k, input logic [63:0] t);
        int s [16];
        int u [16];
        logic [63:0] tkv, res;
        logic [7:0] rcr;
        for (int i = 0; i < 16; i++) s[i] = int'(p[60 - 4 * i +: 4]);
        for (int r = 0; r < 32; r++) begin
            for (int c = 0; c < 4; c++) begin
                s[c] ^= s[8 + c] ^ s[12 + c];
                s[4 + c] ^= s[12 + c];
            end
            rcr = RCV[r];
            s[4] ^= int'(rcr[7:4]);
            s[5] ^= int'(rcr[3:0]);
            tkv = tk_ref(k, t, r);
            for (int i = 0; i < 16; i++) s[i] ^= int'(tkv[60 - 4 * i +: 4]);
            if (r < 31) begin
                for (int i = 0; i < 16; i++) u[PN[i]] = s[i];
                for (int i = 0; i < 16; i++) s[i] = SB[u[i]];
            end
        end
        for (int i = 0; i < 16; i++) res[60 - 4 * i +: 4] = 4'(s[i]);
        return res;
    endfunction

    task automatic launch(input logic [63:0] p, input logic [127:0] k, input logic [63:0] t, input logic hold);
        @(negedge clk);
        chk("ready_before_start", ready, 1'b1);
        pt = p; key = k; tweak = t; start = 1'b1;
        @(posedge clk);
        #1 start = hold;
    endtask

    // counts cycles from the accepting edge until done, checking rc and TK each round
    task automatic wait_done(input logic [127:0] k, input logic [63:0] t, input logic disturb, output int cyc);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
            if (cyc <= 32) begin
                chk("rc_vs_table", dut.rc, craft_pkg::RC_TABLE[cyc - 1]);
                chk("round_tk", dut.tk, tk_ref(k, t, cyc - 1));
                chk("busy_in_flight", {ready, busy, done}, 3'b010);
            end
            if (cyc == 1) tk0_seen = dut.tk;
            if (cyc <= 2) rc_seen[cyc - 1] = dut.rc;
            if (disturb && cyc == 10) begin
                pt = {$urandom, $urandom};
                key = {$urandom, $urandom, $urandom, $urandom};
                tweak = {$urandom, $urandom};
                start = 1'b1;
            end
            if (disturb && cyc == 11) start = 1'b0;
        end while (!done && cyc < 60);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int cyc, pulses;
        logic [63:0] p, t, pb, tb2;
        logic [127:0] k, kb;
        rst = 1'b1; start = 1'b0; pt = '0; key = '0; tweak = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("reset_flags", {ready, busy, done}, 3'b100);
            chk("reset_ct", ct, 64'h0);
        end

        launch(J1_PT, J1_KEY, J1_TWK, 1'b0);
        wait_done(J1_KEY, J1_TWK, 1'b0, cyc);
        chk("j1_latency", cyc, 33);
        chk("j1_tk0", tk0_seen, 64'h736bece593946ee4);
        chk("j1_rc0", rc_seen[0], 8'h11);
        chk("j1_rc1", rc_seen[1], 8'h84);
        chk("j1_ct", ct, ref_ct(J1_PT, J1_KEY, J1_TWK));
        @(negedge clk);
        chk("done_one_cycle", {ready, busy, done}, 3'b100);
        chk("ct_held", ct, ref_ct(J1_PT, J1_KEY, J1_TWK));

        launch(J1_PT, J1_KEY, J1_TWK, 1'b0);
        wait_done(J1_KEY, J1_TWK, 1'b1, cyc);
        chk("disturb_latency", cyc, 33);
        chk("disturb_ct", ct, ref_ct(J1_PT, J1_KEY, J1_TWK));

        p = {$urandom, $urandom}; k = {$urandom, $urandom, $urandom, $urandom}; t = {$urandom, $urandom};
        pb = {$urandom, $urandom}; kb = {$urandom, $urandom, $urandom, $urandom}; tb2 = {$urandom, $urandom};
        launch(p, k, t, 1'b1);
        pt = pb; key = kb; tweak = tb2;
        wait_done(k, t, 1'b0, cyc);
        chk("b2b_a_latency", cyc, 33);
        chk("b2b_a_ct", ct, ref_ct(p, k, t));
        @(negedge clk);
        chk("b2b_idle_gap", {ready, busy, done}, 3'b100);
        @(posedge clk);
        #1 start = 1'b0;
        wait_done(kb, tb2, 1'b0, cyc);
        chk("b2b_b_latency", cyc, 33);
        chk("b2b_b_ct", ct, ref_ct(pb, kb, tb2));

        p = {$urandom, $urandom}; k = {$urandom, $urandom, $urandom, $urandom}; t = {$urandom, $urandom};
        launch(p, k, t, 1'b0);
        repeat (16) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_flags", {ready, busy, done}, 3'b100);
        chk("midrst_ct", ct, 64'h0);
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done || !ready) pulses++;
        end
        chk("midrst_quiet", pulses, 0);
        launch(p, k, t, 1'b0);
        wait_done(k, t, 1'b0, cyc);
        chk("after_rst_latency", cyc, 33);
        chk("after_rst_ct", ct, ref_ct(p, k, t));

        for (int j = 0; j < 1000; j++) begin
            p = {$urandom, $urandom}; k = {$urandom, $urandom, $urandom, $urandom}; t = {$urandom, $urandom};
            repeat ($urandom_range(0, 2)) @(negedge clk);
            launch(p, k, t, 1'b0);
            wait_done(k, t, 1'b0, cyc);
            chk("rand_latency", cyc, 33);
            chk("rand_ct", ct, ref_ct(p, k, t));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
